wb_commit_multi: RTL and testbench
==================================

# wb_commit_multi

Parametrised writeback/commit stage for a NUM_LANES-wide in-order pipeline. Takes the MEM/WB bundle, selects and aligns the register-file write data per lane, and waits for a multi-cycle data-memory response before committing a load. A response that arrives during a freeze is captured and held. Commits the whole bundle atomically and assigns per-lane RVFI retirement order numbers from a shared counter.

## Interface
- NUM_LANES, 2: commit lanes per bundle (1–4)
- XLEN, 32: datapath width
- ORDER_W, 64: retirement order counter width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lane_i  in  wb_lane_t[NUM_LANES]  per lane: valid, opcode, rd_s[4:0], regf_we, regfilemux_sel, alu_out, u_imm, br_en, pc, dmem_addr
- dmem_rdata  in  XLEN  load data word
- dmem_resp  in  1  load data valid, one-cycle pulse
- freeze_stall  in  1  global freeze from upstream
- regf_we_o  out  NUM_LANES  per-lane register-file write enable
- rd_s_o  out  5×NUM_LANES  per-lane destination index
- rd_v_o  out  XLEN×NUM_LANES  per-lane write data
- commit_o  out  NUM_LANES  per-lane retire strobe
- order_o  out  ORDER_W×NUM_LANES  per-lane retirement order
- wb_stall_o  out  1  this stage is holding the bundle while waiting for load data

## Operation
- At most one lane per bundle carries an op_load. The memory lane is the lowest-index valid lane with opcode op_load. A second load in the same bundle is a protocol violation and its behaviour is undefined.
- State machine:
  - IDLE:
    - If the bundle has a valid load and dmem_resp=0, go to WAIT.
    - If dmem_resp=1 and freeze_stall=1, capture dmem_rdata into rdata_q and go to HELD.
  - WAIT:
    - If dmem_resp=1 and freeze_stall=0, commit and go to IDLE.
    - If dmem_resp=1 and freeze_stall=1, capture into rdata_q and go to HELD.
  - HELD:
    - If freeze_stall=0, commit using rdata_q and go to IDLE.
- Load data source: dmem_rdata in the response cycle, otherwise rdata_q while in HELD.
- Bundle ready:
  - No valid load lane, or
  - dmem_resp=1, or
  - state is HELD.
- wb_stall_o = any valid lane and not bundle ready.
- Commit rule: commit_o[i] = lane_i[i].valid & bundle ready & ~freeze_stall & ~rst. The bundle commits all-or-nothing.
- regf_we_o[i] = commit_o[i] & regf_we & (rd_s≠0) & opcode∉{op_br, op_store}.
- rd_v_o[i] by regfilemux_sel:
  - 0: alu_out
  - 1: zero-extended br_en
  - 2: u_imm
  - 3: lw
  - 4: pc+4
  - 5: lb
  - 6: lbu
  - 7: lh
  - 8: lhu
  - any other value: 0
- Load byte/half lane selection uses dmem_addr[1:0]. lb and lh sign-extend.
- Order numbering: order_o[i] = order_q + (count of valid lanes with index < i), computed modulo 2^ORDER_W.
- order_q advances by popcount(commit_o) each cycle.

## Timing
- Reset values: state IDLE, order_q=0, rdata_q=0.
- During reset, commit_o, regf_we_o and wb_stall_o are all 0.
- Non-load bundle: commits in the same cycle it is presented, unless frozen. Zero added latency.
- Load: commits in the cycle dmem_resp is seen, or in the first unfrozen cycle after a held capture.
- Simultaneous dmem_resp and freeze_stall: data is captured, no commit.
- dmem_resp while IDLE with no valid load: ignored, no state change.
- Reset mid-WAIT or mid-HELD: return to IDLE and discard rdata_q. No commit occurs in the reset cycle.
- order_q wrap-around: 2^ORDER_W−1 plus 1 gives 0, with no flag raised.

## Structure
- Package wb_pkg:
  - regfilemux_sel_t enum (4 bits, encodings above)
  - wb_lane_t struct
  - wb_state_t enum {IDLE, WAIT, HELD}
- Sub-module load_align: combinational. Inputs rdata, addr[1:0], sel; output the aligned, extended word. Instantiated once, on the memory lane.
- Everything else lives in the top module.

## Test plan
- Two valid ALU lanes, freeze_stall=0, order_q=0 → commit_o=2'b11, order_o={1,0}, order_q becomes 2 next cycle.
- lb in lane 1, addr[1:0]=2, dmem_rdata=0x00800000, dmem_resp at cycle +3 → wb_stall_o high for 3 cycles, then rd_v_o[1]=0xFFFFFF80 with commit in cycle +3.
- lhu with dmem_resp=1 and freeze_stall=1 in the same cycle, freeze held 2 more cycles, dmem_rdata changed → the captured value is written when freeze_stall drops.
- Lane with rd_s=0 and regf_we=1, and lane with op_store → regf_we_o=0 for both, commit_o=1 for both.
- order_q preset near 2^ORDER_W−1 (e.g. ORDER_W=4 at 15) with two lanes committing → order_o={0,15}, order_q becomes 1.
- rst asserted while in WAIT → next cycle IDLE, no commit; a late dmem_resp with no valid load causes no commit and no state change.

Source files
------------

// File: rtl/wb_commit_multi_pkg.sv
// Shared types for the writeback/commit stage: opcodes, regfile mux select,
// per-lane MEM/WB bundle and commit FSM states.
package wb_pkg;

    localparam int unsigned WB_XLEN = 32;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } opcode_t;

    typedef enum logic [3:0] {
        rf_alu_out  = 4'd0,
        rf_br_en    = 4'd1,
        rf_u_imm    = 4'd2,
        rf_lw       = 4'd3,
        rf_pc_plus4 = 4'd4,
        rf_lb       = 4'd5,
        rf_lbu      = 4'd6,
        rf_lh       = 4'd7,
        rf_lhu      = 4'd8
    } regfilemux_sel_t;

    typedef struct packed {
        logic                valid;
        opcode_t             opcode;
        logic [4:0]          rd_s;
        logic                regf_we;
        regfilemux_sel_t     regfilemux_sel;
        logic [WB_XLEN-1:0]  alu_out;
        logic [WB_XLEN-1:0]  u_imm;
        logic                br_en;
        logic [WB_XLEN-1:0]  pc;
        logic [WB_XLEN-1:0]  dmem_addr;
    } wb_lane_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HELD
    } wb_state_t;

endpackage

// File: rtl/wb_commit_multi_if.sv
// MEM/WB bundle, data-memory response and per-lane commit outputs.
interface wb_commit_multi_if
    import wb_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ORDER_W   = 64
);
    wb_lane_t [NUM_LANES-1:0]                lane_i;
    logic     [XLEN-1:0]                     dmem_rdata;
    logic                                    dmem_resp;
    logic                                    freeze_stall;
    logic     [NUM_LANES-1:0]                regf_we_o;
    logic     [NUM_LANES-1:0][4:0]           rd_s_o;
    logic     [NUM_LANES-1:0][XLEN-1:0]      rd_v_o;
    logic     [NUM_LANES-1:0]                commit_o;
    logic     [NUM_LANES-1:0][ORDER_W-1:0]   order_o;
    logic                                    wb_stall_o;

    modport master (
        output lane_i, dmem_rdata, dmem_resp, freeze_stall,
        input  regf_we_o, rd_s_o, rd_v_o, commit_o, order_o, wb_stall_o
    );

    modport slave (
        input  lane_i, dmem_rdata, dmem_resp, freeze_stall,
        output regf_we_o, rd_s_o, rd_v_o, commit_o, order_o, wb_stall_o
    );
endinterface

// File: rtl/wb_commit_multi_load_align.sv
// Selects the byte/half addressed by addr_i from a load word and extends it.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]  rdata_i,
    input  logic [1:0]       addr_i,
    input  regfilemux_sel_t  sel_i,
    output logic [XLEN-1:0]  data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_i[1], 4'b0000} +: 16];

    always_comb begin
        case (sel_i)
            rf_lb:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            rf_lbu:  data_o = XLEN'(byte_sel);
            rf_lh:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            rf_lhu:  data_o = XLEN'(half_sel);
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/wb_commit_multi.sv
// Writeback/commit stage: waits for load data (holding it across a freeze),
// commits the bundle atomically and numbers retirements for RVFI.
module wb_commit_multi
    import wb_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ORDER_W   = 64
) (
    input  logic         clk,
    input  logic         rst,
    wb_commit_multi_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    wb_state_t              state_q;
    logic [XLEN-1:0]        rdata_q;
    logic [ORDER_W-1:0]     order_q, order_d;

    logic                   has_load;
    logic [IDX_W-1:0]       mem_idx;
    logic [WB_XLEN-1:0]     mem_addr;
    regfilemux_sel_t        mem_sel;
    logic                   ready;
    logic [XLEN-1:0]        ld_word, ld_data;
    logic                   addr_hi_unused;

    logic [NUM_LANES-1:0]               commit, regf_we;
    logic [NUM_LANES-1:0][XLEN-1:0]     rd_v;
    logic [NUM_LANES-1:0][ORDER_W-1:0]  order;
    logic [ORDER_W-1:0]                 acc;
    logic                               any_valid;
    wb_lane_t                           lane;

    // Memory lane: lowest-index valid load.
    always_comb begin
        has_load = 1'b0;
        mem_idx  = '0;
        mem_addr = '0;
        mem_sel  = rf_alu_out;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!has_load && bus.lane_i[i].valid && bus.lane_i[i].opcode == op_load) begin
                has_load = 1'b1;
                mem_idx  = IDX_W'(i);
                mem_addr = bus.lane_i[i].dmem_addr;
                mem_sel  = bus.lane_i[i].regfilemux_sel;
            end
        end
    end

    assign addr_hi_unused = ^{mem_addr[WB_XLEN-1:2], mem_idx};
    assign ready   = !has_load || bus.dmem_resp || (state_q == HELD);
    assign ld_word = bus.dmem_resp ? bus.dmem_rdata : rdata_q;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i (ld_word),
        .addr_i  (mem_addr[1:0]),
        .sel_i   (mem_sel),
        .data_o  (ld_data)
    );

    always_comb begin
        commit    = '0;
        regf_we   = '0;
        rd_v      = '0;
        order     = '0;
        any_valid = 1'b0;
        acc       = order_q;
        order_d   = order_q;
        lane      = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane       = bus.lane_i[i];
            commit[i]  = lane.valid && ready && !bus.freeze_stall && !rst;
            regf_we[i] = commit[i] && lane.regf_we && (lane.rd_s != 5'd0)
                         && (lane.opcode != op_br) && (lane.opcode != op_store);
            order[i]   = acc;
            if (lane.valid) begin
                acc       = acc + ORDER_W'(1);
                any_valid = 1'b1;
            end
            if (commit[i]) order_d = order_d + ORDER_W'(1);
            case (lane.regfilemux_sel)
                rf_alu_out:  rd_v[i] = XLEN'(lane.alu_out);
                rf_br_en:    rd_v[i] = XLEN'(lane.br_en);
                rf_u_imm:    rd_v[i] = XLEN'(lane.u_imm);
                rf_pc_plus4: rd_v[i] = XLEN'(lane.pc + WB_XLEN'(4));
                rf_lw, rf_lb, rf_lbu, rf_lh, rf_lhu: rd_v[i] = ld_data;
                default:     rd_v[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            order_q <= '0;
        end else begin
            order_q <= order_d;
            case (state_q)
                IDLE: if (has_load) begin
                    if (!bus.dmem_resp) begin
                        state_q <= WAIT;
                    end else if (bus.freeze_stall) begin
                        rdata_q <= bus.dmem_rdata;
                        state_q <= HELD;
                    end
                end
                WAIT: if (bus.dmem_resp) begin
                    if (bus.freeze_stall) begin
                        rdata_q <= bus.dmem_rdata;
                        state_q <= HELD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HELD: if (!bus.freeze_stall) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.commit_o   = commit;
    assign bus.regf_we_o  = regf_we;
    assign bus.rd_v_o     = rd_v;
    assign bus.order_o    = order;
    assign bus.wb_stall_o = any_valid && !ready && !rst;

    always_comb begin
        bus.rd_s_o = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) bus.rd_s_o[i] = bus.lane_i[i].rd_s;
    end
endmodule

// File: tb/tb_wb_commit_multi.sv
// Directed bench for wb_commit_multi: stimulus pushes expected commits into a
// scoreboard queue, a negedge monitor pops and compares on every commit.
module tb_wb_commit_multi;
    import wb_pkg::*;

    localparam int unsigned NL = 2;
    localparam int unsigned XW = 32;
    localparam int unsigned OW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_commit_multi_if #(.NUM_LANES(NL), .XLEN(XW), .ORDER_W(OW)) bus ();

    wb_commit_multi #(.NUM_LANES(NL), .XLEN(XW), .ORDER_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NL-1:0]          commit;
        logic [NL-1:0]          we;
        logic [NL-1:0][4:0]     rds;
        logic [NL-1:0][XW-1:0]  rdv;
        logic [NL-1:0][OW-1:0]  ord;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic [1:0] w,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic [31:0] v0, input logic [31:0] v1,
                        input logic [3:0] o0, input logic [3:0] o1);
        exp_t e;
        e.commit = c;   e.we = w;
        e.rds[0] = r0;  e.rds[1] = r1;
        e.rdv[0] = v0;  e.rdv[1] = v1;
        e.ord[0] = o0;  e.ord[1] = o1;
        sb.push_back(e);
    endtask

    function automatic wb_lane_t mk(input opcode_t op, input logic [4:0] rd, input logic we,
                                    input regfilemux_sel_t sel, input logic [31:0] alu);
        wb_lane_t l;
        l = '0;
        l.valid = 1'b1;
        l.opcode = op;
        l.rd_s = rd;
        l.regf_we = we;
        l.regfilemux_sel = sel;
        l.alu_out = alu;
        return l;
    endfunction

    function automatic wb_lane_t alu(input logic [4:0] rd, input logic [31:0] v);
        return mk(op_reg, rd, 1'b1, rf_alu_out, v);
    endfunction

    function automatic wb_lane_t ld(input logic [4:0] rd, input regfilemux_sel_t sel, input logic [31:0] addr);
        wb_lane_t l;
        l = mk(op_load, rd, 1'b1, sel, 32'h0);
        l.dmem_addr = addr;
        return l;
    endfunction

    task automatic drive(input wb_lane_t l0, input wb_lane_t l1, input logic resp,
                         input logic [31:0] rdata, input logic frz);
        bus.lane_i[0]    = l0;
        bus.lane_i[1]    = l1;
        bus.dmem_resp    = resp;
        bus.dmem_rdata   = rdata;
        bus.freeze_stall = frz;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input wb_lane_t l, input logic resp, input logic [31:0] rdata,
                          input logic [31:0] v, input logic we, input logic [3:0] o);
        push(2'b01, {1'b0, we}, l.rd_s, 5'd0, v, 32'h0, o, 4'h0);
        drive(l, '0, resp, rdata, 1'b0);
        step();
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.commit_o != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", 64'(bus.commit_o), 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("commit_o", 64'(bus.commit_o), 64'(e.commit));
                    chk("regf_we_o", 64'(bus.regf_we_o), 64'(e.we));
                    for (int i = 0; i < NL; i++) begin
                        if (e.commit[i]) begin
                            chk($sformatf("rd_s_o[%0d]", i), 64'(bus.rd_s_o[i]), 64'(e.rds[i]));
                            chk($sformatf("rd_v_o[%0d]", i), 64'(bus.rd_v_o[i]), 64'(e.rdv[i]));
                            chk($sformatf("order_o[%0d]", i), 64'(bus.order_o[i]), 64'(e.ord[i]));
                        end
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        wb_lane_t a, b, l;

        rst = 1'b1;
        drive(ld(5'd1, rf_lw, 32'h0), '0, 1'b0, 32'h0, 1'b0);
        chk("rst_stall", 64'(bus.wb_stall_o), 64'h0);
        chk("rst_commit", 64'(bus.commit_o), 64'h0);
        step();
        step();
        rst = 1'b0;
        drive('0, '0, 1'b0, 32'h0, 1'b0);
        chk("reset_order", 64'(bus.order_o[0]), 64'h0);
        chk("idle_stall", 64'(bus.wb_stall_o), 64'h0);
        step();

        // Two ALU lanes
        a = alu(5'd3, 32'h11);
        b = alu(5'd4, 32'h22);
        push(2'b11, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22, 4'd0, 4'd1);
        drive(a, b, 1'b0, 32'h0, 1'b0);
        step();

        // rd_s=0 and store: commit but no regfile write
        a = alu(5'd0, 32'h33);
        b = mk(op_store, 5'd5, 1'b1, rf_alu_out, 32'h44);
        push(2'b11, 2'b00, 5'd0, 5'd5, 32'h33, 32'h44, 4'd2, 4'd3);
        drive(a, b, 1'b0, 32'h0, 1'b0);
        step();

        // lb in lane 1, response three cycles later
        a = alu(5'd6, 32'h55);
        b = ld(5'd7, rf_lb, 32'h0000_0102);
        for (int k = 0; k < 3; k++) begin
            drive(a, b, 1'b0, 32'hDEAD_0000, 1'b0);
            chk($sformatf("lb_wait_stall%0d", k), 64'(bus.wb_stall_o), 64'h1);
            chk($sformatf("lb_wait_commit%0d", k), 64'(bus.commit_o), 64'h0);
            step();
        end
        push(2'b11, 2'b11, 5'd6, 5'd7, 32'h55, 32'hFFFF_FF80, 4'd4, 4'd5);
        drive(a, b, 1'b1, 32'h0080_0000, 1'b0);
        chk("lb_resp_stall", 64'(bus.wb_stall_o), 64'h0);
        step();

        // lhu: response under freeze is captured, data bus changes afterwards
        a = ld(5'd11, rf_lhu, 32'h0000_0002);
        drive(a, '0, 1'b1, 32'hBEEF_1234, 1'b1);
        chk("lhu_capture_commit", 64'(bus.commit_o), 64'h0);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(a, '0, 1'b0, 32'hDEAD_DEAD, 1'b1);
            chk($sformatf("lhu_held_stall%0d", k), 64'(bus.wb_stall_o), 64'h0);
            chk($sformatf("lhu_held_commit%0d", k), 64'(bus.commit_o), 64'h0);
            step();
        end
        push(2'b01, 2'b01, 5'd11, 5'd0, 32'h0000_BEEF, 32'h0, 4'd6, 4'd0);
        drive(a, '0, 1'b0, 32'hDEAD_DEAD, 1'b0);
        step();

        // Reset while waiting, then a late response with no load
        b = ld(5'd8, rf_lw, 32'h0);
        drive('0, b, 1'b0, 32'h0, 1'b0);
        chk("pre_rst_stall", 64'(bus.wb_stall_o), 64'h1);
        step();
        rst = 1'b1;
        drive('0, b, 1'b0, 32'h0, 1'b0);
        chk("rst_wait_commit", 64'(bus.commit_o), 64'h0);
        chk("rst_wait_stall", 64'(bus.wb_stall_o), 64'h0);
        step();
        rst = 1'b0;
        drive('0, '0, 1'b1, 32'h1234_5678, 1'b1);
        chk("late_resp_commit", 64'(bus.commit_o), 64'h0);
        step();
        a = ld(5'd9, rf_lw, 32'h0);
        b = alu(5'd10, 32'h66);
        drive(a, b, 1'b0, 32'h0, 1'b0);
        chk("idle_after_late_resp_stall", 64'(bus.wb_stall_o), 64'h1);
        step();
        push(2'b11, 2'b11, 5'd9, 5'd10, 32'hCAFE_F00D, 32'h66, 4'd0, 4'd1);
        drive(a, b, 1'b1, 32'hCAFE_F00D, 1'b0);
        step();

        // Single-lane bundles over the remaining mux selects, order 2..14
        l = mk(op_br, 5'd12, 1'b1, rf_br_en, 32'h0);
        l.br_en = 1'b1;
        single(l, 1'b0, 32'h0, 32'h1, 1'b0, 4'd2);
        l = mk(op_lui, 5'd13, 1'b1, rf_u_imm, 32'h0);
        l.u_imm = 32'h1234_5000;
        single(l, 1'b0, 32'h0, 32'h1234_5000, 1'b1, 4'd3);
        l = mk(op_jal, 5'd14, 1'b1, rf_pc_plus4, 32'h0);
        l.pc = 32'h0000_1000;
        single(l, 1'b0, 32'h0, 32'h0000_1004, 1'b1, 4'd4);
        l = mk(op_reg, 5'd15, 1'b1, regfilemux_sel_t'(4'hF), 32'hFFFF);
        single(l, 1'b0, 32'h0, 32'h0, 1'b1, 4'd5);
        single(ld(5'd16, rf_lh, 32'h0), 1'b1, 32'h0000_8001, 32'hFFFF_8001, 1'b1, 4'd6);
        single(ld(5'd17, rf_lbu, 32'h3), 1'b1, 32'h80AA_5511, 32'h0000_0080, 1'b1, 4'd7);
        single(ld(5'd18, rf_lb, 32'h0), 1'b1, 32'h0000_007F, 32'h0000_007F, 1'b1, 4'd8);
        single(ld(5'd19, rf_lh, 32'h2), 1'b1, 32'hC001_0000, 32'hFFFF_C001, 1'b1, 4'd9);
        for (int k = 0; k < 5; k++)
            single(alu(5'd1, 32'h100 + k), 1'b0, 32'h0, 32'h100 + k, 1'b1, 4'(10 + k));

        // Order counter wrap: 15 then 0, next bundle starts at 1
        push(2'b11, 2'b11, 5'd2, 5'd3, 32'hA, 32'hB, 4'd15, 4'd0);
        drive(alu(5'd2, 32'hA), alu(5'd3, 32'hB), 1'b0, 32'h0, 1'b0);
        step();
        single(alu(5'd4, 32'hC), 1'b0, 32'h0, 32'hC, 1'b1, 4'd1);

        drive('0, '0, 1'b0, 32'h0, 1'b0);
        step();
        step();
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
